// File: rtl/axis_switch_pkg.sv
// Shared types and helpers for the AXI-Stream switch grant controller.
package axis_switch_pkg;

  typedef enum logic [1:0] {IDLE, GRANT, DROP} arb_state_t;

  function automatic int sel_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Master idx owns [base + idx*stride, base + idx*stride + range].
  function automatic logic dest_match(input logic [31:0] dest, input int idx,
                                      input int base, input int stride, input int range);
    logic [31:0] lo;
    logic [31:0] hi;
    lo = 32'(base) + 32'(idx) * 32'(stride);
    hi = lo + 32'(range);
    return (dest >= lo) && (dest <= hi);
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin request picker: first set request after ptr, wrapping modulo NSLAVES.
module rr_priority_picker
  import axis_switch_pkg::*;
#(
  parameter int NSLAVES = 4,
  localparam int SW = sel_bits(NSLAVES)
) (
  input  logic [NSLAVES-1:0] req,
  input  logic [SW-1:0]      ptr,
  output logic [SW-1:0]      win,
  output logic               any_req
);

  always_comb begin
    int idx;
    idx     = 0;
    win     = '0;
    any_req = 1'b0;
    for (int k = 1; k <= NSLAVES; k++) begin
      idx = (int'(ptr) + k) % NSLAVES;
      if (req[idx] && !any_req) begin
        win     = SW'(idx);
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axis_switch_rr_arbiter.sv
// Grant controller for an NSLAVES x NMASTERS AXI-Stream switch: round-robin
// slave pick, TDEST decode, grant held to end of packet, unrouted packets dropped.
module axis_switch_rr_arbiter
  import axis_switch_pkg::*;
#(
  parameter int NSLAVES     = 4,
  parameter int NMASTERS    = 2,
  parameter int HAS_LAST    = 1,
  parameter int HAS_DEST    = 1,
  parameter int DEST_WIDTH  = 8,
  parameter int DEST_BASE   = 0,
  parameter int DEST_STRIDE = 1,
  parameter int DEST_RANGE  = 0,
  localparam int SW = sel_bits(NSLAVES),
  localparam int MW = sel_bits(NMASTERS)
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic [NSLAVES-1:0]              s_valid,
  input  logic [NSLAVES-1:0]              s_last,
  input  logic [NSLAVES*DEST_WIDTH-1:0]   s_dest,
  input  logic [NMASTERS-1:0]             m_ready,
  output logic [NSLAVES-1:0]              s_ready,
  output logic [NMASTERS-1:0]             m_valid,
  output logic [SW-1:0]                   sel_slave,
  output logic [MW-1:0]                   sel_master,
  output logic                            busy,
  output logic                            err_unrouted
);

  arb_state_t    state_q, state_d;
  logic [SW-1:0] rr_ptr_q, rr_ptr_d;
  logic [SW-1:0] sel_slave_q, sel_slave_d;
  logic [MW-1:0] sel_master_q, sel_master_d;
  logic          err_q, err_d;

  logic [SW-1:0]         pick;
  logic                  any_req;
  logic [DEST_WIDTH-1:0] win_dest;
  logic                  dec_hit;
  logic [MW-1:0]         dec_idx;
  logic                  eop;

  rr_priority_picker #(.NSLAVES(NSLAVES)) u_picker (
    .req     (s_valid),
    .ptr     (rr_ptr_q),
    .win     (pick),
    .any_req (any_req)
  );

  assign win_dest = s_dest[int'(pick)*DEST_WIDTH +: DEST_WIDTH];

  // Descending scan so the lowest matching master index wins on overlap.
  always_comb begin
    dec_hit = 1'b0;
    dec_idx = '0;
    if (HAS_DEST == 0 || NMASTERS == 1) begin
      dec_hit = 1'b1;
    end else begin
      for (int i = NMASTERS - 1; i >= 0; i--) begin
        if (dest_match(32'(win_dest), i, DEST_BASE, DEST_STRIDE, DEST_RANGE)) begin
          dec_hit = 1'b1;
          dec_idx = MW'(i);
        end
      end
    end
  end

  // Handshake steering is decoded from registered selects only, so IDLE
  // never passes s_valid through to s_ready.
  always_comb begin
    s_ready = '0;
    m_valid = '0;
    eop     = 1'b0;
    case (state_q)
      GRANT: begin
        m_valid[sel_master_q] = s_valid[sel_slave_q];
        s_ready[sel_slave_q]  = m_ready[sel_master_q];
        eop = s_valid[sel_slave_q] && m_ready[sel_master_q] &&
              ((HAS_LAST == 0) || s_last[sel_slave_q]);
      end
      DROP: begin
        s_ready[sel_slave_q] = 1'b1;
        eop = s_valid[sel_slave_q] && ((HAS_LAST == 0) || s_last[sel_slave_q]);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    sel_slave_d  = sel_slave_q;
    sel_master_d = sel_master_q;
    err_d        = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          sel_slave_d  = pick;
          sel_master_d = dec_hit ? dec_idx : '0;
          state_d      = dec_hit ? GRANT : DROP;
          err_d        = !dec_hit;
        end
      end
      GRANT, DROP: begin
        if (eop) begin
          rr_ptr_d = sel_slave_q;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= IDLE;
      rr_ptr_q     <= SW'(NSLAVES - 1);
      sel_slave_q  <= '0;
      sel_master_q <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      sel_slave_q  <= sel_slave_d;
      sel_master_q <= sel_master_d;
      err_q        <= err_d;
    end
  end

  assign sel_slave    = sel_slave_q;
  assign sel_master   = sel_master_q;
  assign busy         = (state_q != IDLE);
  assign err_unrouted = err_q;

endmodule

// File: doc/axis_switch_rr_arbiter.md
Name: axis_switch_rr_arbiter

Overview:
- Grant controller for an NSLAVES x NMASTERS AXI-Stream packet switch. The datapath mux is a separate block.
- Picks one requesting slave with round-robin fairness and decodes its TDEST to a master port.
- Holds the slave/master pairing until the packet's last beat is accepted.
- Discards packets whose TDEST matches no master and flags the error.

Parameters:
- NSLAVES, 4, number of slave (input) ports, >=2.
- NMASTERS, 2, number of master (output) ports, >=1.
- HAS_LAST, 1, 1: grant held until beat with s_last; 0: every beat is a packet.
- HAS_DEST, 1, 0: all traffic routes to master 0, no decode.
- DEST_WIDTH, 8, TDEST width per slave.
- DEST_BASE, 0, TDEST value mapped to master 0.
- DEST_STRIDE, 1, TDEST step between consecutive masters.
- DEST_RANGE, 0, 0: exact match; else master i accepts BASE+i*STRIDE .. BASE+i*STRIDE+RANGE inclusive.

Ports:
- aclk, in, 1, clock.
- aresetn, in, 1, asynchronous active-low reset.
- s_valid, in, NSLAVES, TVALID per slave.
- s_last, in, NSLAVES, TLAST per slave.
- s_dest, in, NSLAVES*DEST_WIDTH, TDEST per slave, packed slave 0 at LSBs.
- m_ready, in, NMASTERS, TREADY per master.
- s_ready, out, NSLAVES, TREADY returned to slaves.
- m_valid, out, NMASTERS, TVALID driven to masters.
- sel_slave, out, max(1,$clog2(NSLAVES)), mux select for datapath.
- sel_master, out, max(1,$clog2(NMASTERS)), demux select for datapath.
- busy, out, 1, grant active (GRANT or DROP).
- err_unrouted, out, 1, one-cycle pulse when a packet is committed to DROP.

Behaviour:
- Reset (async assert, sync release): state=IDLE, rr_ptr=NSLAVES-1, sel_slave=0, sel_master=0, err_unrouted=0. All outputs except sel_* are 0.
- States: IDLE, GRANT, DROP.
- IDLE arbitration:
  - Search slaves rr_ptr+1, rr_ptr+2, ... modulo NSLAVES; first j with s_valid[j]=1 wins.
  - Register sel_slave=j. Decode s_dest[j] and register sel_master.
  - Go to GRANT, or to DROP if no master matched.
  - No s_valid set: stay in IDLE.
  - Grant latency: 1 cycle from first s_valid to m_valid.
- Decode:
  - Lowest master index wins on overlapping ranges.
  - Compare in 32-bit unsigned arithmetic; DEST_WIDTH is zero-extended.
  - HAS_DEST=0 or NMASTERS=1: always master 0, never DROP.
- GRANT:
  - m_valid[sel_master]=s_valid[sel_slave]; s_ready[sel_slave]=m_ready[sel_master]. All other bits 0.
  - A beat transfers when both are 1.
  - End of packet: beat transfers and (HAS_LAST=0 or s_last[sel_slave]=1). Then rr_ptr<=sel_slave and state<=IDLE.
- DROP:
  - s_ready[sel_slave]=1; m_valid all 0.
  - End of packet on s_valid[sel_slave] with last (or any beat when HAS_LAST=0). Then rr_ptr updates and state<=IDLE.
  - err_unrouted pulses in the cycle IDLE->DROP.
- At least one IDLE cycle between packets. No combinational path from s_valid to s_ready in IDLE.
- s_dest is sampled only in IDLE; later changes mid-packet are ignored.
- m_ready deasserting mid-packet stalls; the grant is held indefinitely.
- s_valid dropping mid-packet holds the grant; no timeout.
- Reset mid-packet: immediate IDLE, s_ready/m_valid drop asynchronously, rr_ptr returns to NSLAVES-1.
- Arbitration uses only s_valid, never s_last. A single-beat packet grants and ends in GRANT.

Decomposition:
- Shared package axis_switch_pkg holds:
  - state enum arb_state_t {IDLE, GRANT, DROP}.
  - function dest_match(dest, idx, BASE, STRIDE, RANGE).
  - localparam helper sel_bits(n) = max(1,$clog2(n)).
- Sub-module rr_priority_picker (NSLAVES): combinational request vector + rr_ptr -> winner index + any_req.

Test Plan:
- NSLAVES=4, NMASTERS=2, STRIDE=4, RANGE=3, HAS_LAST=1. Slaves 0,2 valid at reset, dest 1 and 5, 3-beat packets, m_ready=1 -> slave 0 to master 0 (sel_master=0), idle cycle, then slave 2 to master 1. rr_ptr=2 afterwards.
- All 4 slaves continuously valid, single-beat packets -> grant order 0,1,2,3,0,1; one packet every 2 cycles.
- Slave 1 dest=200 (unmatched) -> err_unrouted=1 for one cycle, s_ready[1]=1 for all 4 beats, m_valid=0, then IDLE.
- Grant slave 3 to master 1, m_ready[1]=0 for 5 cycles mid-packet -> s_ready[3]=0, state held. Resume -> remaining beats pass; last beat returns to IDLE.
- Assert aresetn=0 during beat 2 of a 4-beat packet -> s_ready and m_valid are 0 within the same cycle. After release, slave 0 wins first.
- HAS_LAST=0, slave 2 holding s_last=0 -> grant released after every accepted beat.
